// File: rtl/inst_rom_pipe.sv
// inst_rom_pipe: writable instruction memory with a fetch request/response
// handshake, 1- or 2-cycle read latency, a program-load port and
// alignment/range fault reporting.
// Optional build macro INST_ROM_PARITY_EN: stores an even-parity bit per word,
// widens resp_fault to 3 bits (bit2 = parity error) and adds parity_inject.
module inst_rom_pipe #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 6,
  parameter int                PC_W     = 32,
  parameter int                LATENCY  = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [PC_W-1:0]   fetch_pc,
  output logic              fetch_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_inst,
  output logic [PC_W-1:0]   resp_pc,
`ifdef INST_ROM_PARITY_EN
  output logic [2:0]        resp_fault,
  input  logic              parity_inject,
`else
  output logic [1:0]        resp_fault,
`endif
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef INST_ROM_PARITY_EN
  localparam int FAULT_W = 3;
  localparam int MEM_W   = DATA_W + 1;
`else
  localparam int FAULT_W = 2;
  localparam int MEM_W   = DATA_W;
`endif

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

  if ((LATENCY != 1) && (LATENCY != 2)) begin : g_bad_latency
    $error("inst_rom_pipe: LATENCY must be 1 or 2");
  end

  logic               advance_s;
  logic               accept_s;
  logic [ADDR_W-1:0]  req_idx_s;
  logic [1:0]         req_flt_s;

  logic               src_valid_s;
  logic [ADDR_W-1:0]  src_idx_s;
  logic [PC_W-1:0]    src_pc_s;
  logic [1:0]         src_flt_s;

  logic [MEM_W-1:0]   mem_r [DEPTH];
  logic [MEM_W-1:0]   wr_word_s;
  logic [MEM_W-1:0]   rd_word_s;
  logic [DATA_W-1:0]  nxt_inst_s;
  logic [FAULT_W-1:0] nxt_flt_s;

  // Handshake: every stage moves together when the output slot frees up;
  // a program write blocks new fetches for that cycle.
  always_comb begin
    advance_s   = !resp_valid || resp_ready;
    fetch_ready = advance_s && !prog_we;
    accept_s    = fetch_valid && fetch_ready;
    req_idx_s   = fetch_pc[ADDR_W+1:2];
    req_flt_s   = 2'b00;
    req_flt_s[0] = (fetch_pc[1:0] != 2'b00);
    req_flt_s[1] = ((fetch_pc >> (ADDR_W + 2)) != {PC_W{1'b0}});
  end

  if (LATENCY == 2) begin : g_s1
    logic              s1_valid_r;
    logic [ADDR_W-1:0] s1_idx_r;
    logic [PC_W-1:0]   s1_pc_r;
    logic [1:0]        s1_flt_r;

    // Request stage: captures the accepted request (or a bubble) on advance.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid_r <= 1'b0;
        s1_idx_r   <= {ADDR_W{1'b0}};
        s1_pc_r    <= {PC_W{1'b0}};
        s1_flt_r   <= 2'b00;
      end else if (advance_s) begin
        s1_valid_r <= accept_s;
        s1_idx_r   <= req_idx_s;
        s1_pc_r    <= fetch_pc;
        s1_flt_r   <= req_flt_s;
      end
    end

    assign src_valid_s = s1_valid_r;
    assign src_idx_s   = s1_idx_r;
    assign src_pc_s    = s1_pc_r;
    assign src_flt_s   = s1_flt_r;
  end else begin : g_s0
    assign src_valid_s = accept_s;
    assign src_idx_s   = req_idx_s;
    assign src_pc_s    = fetch_pc;
    assign src_flt_s   = req_flt_s;
  end

  // Word presented to the array, with its parity bit when parity is built in.
  always_comb begin
`ifdef INST_ROM_PARITY_EN
    wr_word_s = {even_parity(prog_data) ^ parity_inject, prog_data};
`else
    wr_word_s = prog_data;
`endif
  end

  // Instruction array: written from the program port, never reset.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_r[prog_addr] <= wr_word_s;
    end
  end

  // Array read with write-first bypass, so a same-edge write to the index
  // being read is what the response carries.
  always_comb begin
    if (prog_we && (prog_addr == src_idx_s)) begin
      rd_word_s = wr_word_s;
    end else begin
      rd_word_s = mem_r[src_idx_s];
    end
  end

  // Response word and fault flags: any fault substitutes the NOP word.
  always_comb begin
    nxt_flt_s      = {FAULT_W{1'b0}};
    nxt_flt_s[1:0] = src_flt_s;
    if (src_flt_s != 2'b00) begin
      nxt_inst_s = NOP_WORD;
    end else begin
`ifdef INST_ROM_PARITY_EN
      if (even_parity(rd_word_s[DATA_W-1:0]) != rd_word_s[DATA_W]) begin
        nxt_flt_s[2] = 1'b1;
        nxt_inst_s   = NOP_WORD;
      end else begin
        nxt_inst_s = rd_word_s[DATA_W-1:0];
      end
`else
      nxt_inst_s = rd_word_s;
`endif
    end
  end

  // Output register: loads on advance; payload only updates for valid slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_inst  <= NOP_WORD;
      resp_pc    <= {PC_W{1'b0}};
      resp_fault <= {FAULT_W{1'b0}};
    end else if (advance_s) begin
      resp_valid <= src_valid_s;
      if (src_valid_s) begin
        resp_inst  <= nxt_inst_s;
        resp_pc    <= src_pc_s;
        resp_fault <= nxt_flt_s;
      end
    end
  end

endmodule

// File: tb/tb_inst_rom_pipe.sv
// Testbench for inst_rom_pipe: one LATENCY=1 and one LATENCY=2 instance share
// stimulus; a select steers the handshake to the active instance while the
// idle one drains. A negedge monitor scores responses against a queue model.
module tb_inst_rom_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = 32'h0;
  logic        resp_ready = 1'b1;
  logic        prog_we = 1'b0;
  logic [5:0]  prog_addr = 6'h0;
  logic [31:0] prog_data = 32'h0;

  logic        fr1, rv1, fr2, rv2;
  logic [31:0] ri1, rp1, ri2, rp2;
  logic [1:0]  rf1, rf2;

  wire fv1 = fetch_valid && !sel;
  wire rr1 = resp_ready || sel;
  wire fv2 = fetch_valid && sel;
  wire rr2 = resp_ready || !sel;

  wire        fetch_ready = sel ? fr2 : fr1;
  wire        resp_valid  = sel ? rv2 : rv1;
  wire [31:0] resp_inst   = sel ? ri2 : ri1;
  wire [31:0] resp_pc     = sel ? rp2 : rp1;
  wire [1:0]  resp_fault  = sel ? rf2 : rf1;

  inst_rom_pipe #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .fetch_valid(fv1), .fetch_pc(fetch_pc),
    .fetch_ready(fr1), .resp_valid(rv1), .resp_ready(rr1), .resp_inst(ri1),
    .resp_pc(rp1), .resp_fault(rf1), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  inst_rom_pipe #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .fetch_valid(fv2), .fetch_pc(fetch_pc),
    .fetch_ready(fr2), .resp_valid(rv2), .resp_ready(rr2), .resp_inst(ri2),
    .resp_pc(rp2), .resp_fault(rf2), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [64];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b1;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_inst, hold_pc;
  logic [1:0]  hold_fault;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected response for a fetch, from the addressing rules.
  function automatic exp_t model(input logic [31:0] pc);
    exp_t e;
    e.pc       = pc;
    e.fault[0] = (pc % 4) != 0;
    e.fault[1] = (pc / 256) != 0;
    e.inst     = (e.fault != 2'b00) ? 32'h0 : ref_mem[(pc / 4) % 64];
    return e;
  endfunction

  // Monitor: handshake rule, hold stability, scoreboard, reference memory.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      check("fetch_ready", 64'(fetch_ready), 64'((!resp_valid || resp_ready) && !prog_we));
      if (hold_prev) begin
        check("hold_valid", 64'(resp_valid), 64'(1'b1));
        check("hold_inst", 64'(resp_inst), 64'(hold_inst));
        check("hold_pc", 64'(resp_pc), 64'(hold_pc));
        check("hold_fault", 64'(resp_fault), 64'(hold_fault));
      end
      if (mon_en && fetch_valid && fetch_ready) exp_q.push_back(model(fetch_pc));
      if (mon_en && resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL resp_unexpected: observed pc %0h with no request outstanding", resp_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_pc", 64'(resp_pc), 64'(e.pc));
          check("sb_inst", 64'(resp_inst), 64'(e.inst));
          check("sb_fault", 64'(resp_fault), 64'(e.fault));
        end
      end
      if (prog_we) ref_mem[prog_addr] = prog_data;
      hold_prev  = resp_valid && !resp_ready;
      hold_inst  = resp_inst;
      hold_pc    = resp_pc;
      hold_fault = resp_fault;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input logic [5:0] idx, input logic [31:0] data);
    prog_we   = 1'b1;
    prog_addr = idx;
    prog_data = data;
    cyc();
    prog_we = 1'b0;
  endtask

  task automatic drain();
    fetch_valid = 1'b0;
    resp_ready  = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      int r;
      fetch_valid = ($urandom % 4) != 0;
      resp_ready  = ($urandom % 4) != 0;
      r = $urandom % 10;
      if (r < 8)       fetch_pc = 32'($urandom_range(0, 63)) << 2;
      else if (r == 8) fetch_pc = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else             fetch_pc = $urandom;
      cyc();
    end
    drain();
  endtask

  initial begin
    logic [31:0] flt_pc [3];
    logic [1:0]  flt_exp [3];
    flt_pc  = '{32'h6, 32'h100, 32'h102};
    flt_exp = '{2'b01, 2'b10, 2'b11};

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    check("rst_valid_l1", 64'(rv1), 64'd0);
    check("rst_inst_l1", 64'(ri1), 64'd0);
    check("rst_pc_l1", 64'(rp1), 64'd0);
    check("rst_fault_l1", 64'(rf1), 64'd0);
    check("rst_valid_l2", 64'(rv2), 64'd0);
    check("rst_fault_l2", 64'(rf2), 64'd0);

    // Program image.
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = (i == 0) ? 32'hA5A5_5A5A : (i == 1) ? 32'h0010_1464 :
          (i == 2) ? 32'h2800_3826 : ($urandom | 32'h1);
      prog_write(6'(i), w);
    end

    // LATENCY=1 load-then-fetch.
    sel = 1'b0;
    fetch_valid = 1'b1; fetch_pc = 32'h4; resp_ready = 1'b1;
    cyc();
    check("l1_first_valid", 64'(resp_valid), 64'd1);
    check("l1_first_inst", 64'(resp_inst), 64'h0010_1464);
    check("l1_first_pc", 64'(resp_pc), 64'h4);
    fetch_pc = 32'h8;
    cyc();
    check("l1_second_valid", 64'(resp_valid), 64'd1);
    check("l1_second_inst", 64'(resp_inst), 64'h2800_3826);
    check("l1_second_pc", 64'(resp_pc), 64'h8);
    check("l1_second_fault", 64'(resp_fault), 64'd0);

    // Fault responses.
    for (int i = 0; i < 3; i++) begin
      fetch_pc = flt_pc[i];
      cyc();
      check("fault_flags", 64'(resp_fault), 64'(flt_exp[i]));
      check("fault_nop", 64'(resp_inst), 64'd0);
    end
    fetch_valid = 1'b0;
    cyc();
    check("l1_bubble", 64'(resp_valid), 64'd0);
    drain();
    run_random(300);

    // LATENCY=2 streaming.
    sel = 1'b1;
    resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      fetch_valid = (k < 4);
      fetch_pc    = 32'(k * 4);
      cyc();
      check("l2_stream_valid", 64'(resp_valid), 64'((k >= 1) && (k <= 4)));
      if ((k >= 1) && (k <= 4)) begin
        check("l2_stream_pc", 64'(resp_pc), 64'((k - 1) * 4));
        check("l2_stream_inst", 64'(resp_inst), 64'(ref_mem[k - 1]));
      end
    end

    // Backpressure on LATENCY=2.
    fetch_valid = 1'b1; fetch_pc = 32'h10; resp_ready = 1'b0;
    cyc();
    fetch_pc = 32'h14;
    cyc();
    check("bp_valid", 64'(resp_valid), 64'd1);
    fetch_pc = 32'h18;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("bp_fetch_ready", 64'(fetch_ready), 64'd0);
      check("bp_pc", 64'(resp_pc), 64'h10);
      check("bp_inst", 64'(resp_inst), 64'(ref_mem[4]));
    end
    resp_ready = 1'b1; fetch_valid = 1'b0;
    cyc();
    check("bp_release_pc", 64'(resp_pc), 64'h14);
    check("bp_release_inst", 64'(resp_inst), 64'(ref_mem[5]));
    cyc();
    check("bp_after_valid", 64'(resp_valid), 64'd0);
    drain();

    // Program-port collision with an in-flight read.
    mon_en = 1'b0;
    fetch_valid = 1'b1; fetch_pc = 32'hC;
    cyc();
    fetch_valid = 1'b0;
    prog_we = 1'b1; prog_addr = 6'd3; prog_data = 32'h3fff_f0e8;
    #1;
    check("coll_fetch_ready", 64'(fetch_ready), 64'd0);
    cyc();
    prog_we = 1'b0;
    check("coll_valid", 64'(resp_valid), 64'd1);
    check("coll_inst", 64'(resp_inst), 64'h3fff_f0e8);
    check("coll_pc", 64'(resp_pc), 64'hC);
    cyc();
    exp_q.delete();
    mon_en = 1'b1;

    // Async reset with two requests in flight.
    fetch_valid = 1'b1; fetch_pc = 32'h4;
    cyc();
    fetch_pc = 32'h8;
    cyc();
    fetch_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid_now", 64'(resp_valid), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("arst_no_resp", 64'(resp_valid), 64'd0);
    end
    fetch_valid = 1'b1; fetch_pc = 32'h4;
    cyc();
    fetch_valid = 1'b0;
    cyc();
    check("arst_refetch_valid", 64'(resp_valid), 64'd1);
    check("arst_refetch_inst", 64'(resp_inst), 64'h0010_1464);
    drain();
    run_random(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_rom_pipe.md
Name: inst_rom_pipe

Overview:
- Parametrised successor to the fixed 64x32 combinational instruction ROM.
- Synchronous, writable instruction memory with a fetch request/response handshake and configurable read latency (1 or 2 cycles).
- Includes a program-load port so the test bench or boot logic can write the image, plus alignment/range fault reporting.
- Sits between the PC/fetch stage and decode of the multi-cycle/pipelined CPU variants.

Parameters:
- DATA_W, 32, instruction word width in bits.
- ADDR_W, 6, word-index width; depth = 2**ADDR_W words.
- PC_W, 32, byte-address width of the fetch PC.
- LATENCY, 1, read latency in cycles (legal values 1 or 2; any other value is a elaboration error).
- NOP_WORD, 32'h00000000, word returned on faulting fetches.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- fetch_valid  in  1  fetch request present.
- fetch_pc  in  PC_W  byte address of the requested instruction.
- fetch_ready  out  1  request accepted this cycle when both valid and ready are high.
- resp_valid  out  1  resp_inst/resp_fault hold a result.
- resp_ready  in  1  consumer takes the result this cycle.
- resp_inst  out  DATA_W  fetched instruction.
- resp_pc  out  PC_W  PC of the returned instruction.
- resp_fault  out  2  bit0 = misaligned, bit1 = out of range.
- prog_we  in  1  program-port write strobe.
- prog_addr  in  ADDR_W  word index to write.
- prog_data  in  DATA_W  word to write.

Behaviour:
- Reset (async, rst=1): resp_valid=0, resp_inst=NOP_WORD, resp_pc=0, resp_fault=0, and all internal stage-valid bits are 0. Array contents are not cleared.
- Pipeline advance: advance = !resp_valid || resp_ready. All stages shift only when advance=1; otherwise every stage holds.
- fetch_ready = advance && !prog_we. A request is accepted on the edge where fetch_valid && fetch_ready.
- Index = fetch_pc[ADDR_W+1:2].
- Misaligned fault: fetch_pc[1:0] != 0.
- Out-of-range fault: any fetch_pc bit above ADDR_W+1 is set.
- Any fault: resp_inst=NOP_WORD, no array read is attempted, resp_fault carries the flags, and both bits may be set together.
- LATENCY=1: the response is registered on the accept edge, so resp_valid=1 in the next cycle.
- LATENCY=2: the accept edge loads stage s1 (index, pc, fault, valid); the next advancing edge loads the output register.
- Bubbles: with fetch_valid=0 on an advancing edge, a 0-valid bubble propagates.
- Back-to-back: one request per cycle is sustained while resp_ready=1.
- Backpressure: while resp_valid && !resp_ready, the outputs and s1 are held stable and fetch_ready=0.
- Program port: a write occurs on the edge where prog_we=1, regardless of pipeline state.
  - prog_we forces fetch_ready=0, so no new fetch is accepted that cycle.
  - A read already in flight (s1, LATENCY=2) to the same index returns the new data: write-first, with the array read on the edge s1 advances.
- Reset mid-operation: in-flight requests are discarded and no response is produced for them. The array holds its last written contents.

Optional Feature:
- Macro INST_ROM_PARITY_EN.
- Defined:
  - Each array word stores an extra even-parity bit computed from prog_data on write.
  - A read recomputes parity; on mismatch resp_fault gains bit2 (the port widens to 3 bits) and resp_inst returns NOP_WORD.
  - Adds input port parity_inject (1 bit): while high, the program port writes an inverted parity bit, for test use.
- Undefined: no parity storage, resp_fault is 2 bits, and no parity_inject port exists.

Test Plan:
- Reset then load: write words 0x00101464 at idx1 and 0x28003826 at idx2. Fetch pc=0x4 then 0x8 with resp_ready=1, LATENCY=1. Required: responses 0x00101464 then 0x28003826 on consecutive cycles, pc echoed, fault=0.
- LATENCY=2 streaming: 4 back-to-back fetches at pc 0x0,0x4,0x8,0xC. Required: first resp_valid exactly 2 cycles after the first accept, then 4 consecutive valid cycles in order.
- Backpressure: hold resp_ready=0 for 3 cycles with a result pending. Required: resp_inst/resp_pc stable, fetch_ready=0, and no lost or duplicated response after release.
- Faults: fetch pc=0x6 gives fault=2'b01 and inst=0x00000000. Fetch pc=0x100 (ADDR_W=6) gives fault=2'b10. Fetch pc=0x102 gives fault=2'b11.
- Program collision: with LATENCY=2, accept a fetch of idx3, then write idx3=0x3ffff0e8 the next cycle. Required: the response returns 0x3ffff0e8, and fetch_ready=0 during prog_we.
- Async reset mid-stream: assert rst between edges with 2 requests in flight. Required: resp_valid drops immediately and no response appears after release. Re-fetch of idx1 still returns 0x00101464.
